// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute sequencer: one instruction per IDLE->FETCH->EXEC pass, with
// halt control, a sticky fetch-timeout fault and a retired-instruction counter.
module fetch_exec_sequencer #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_in_i,
  output logic            pc_step_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic [ILEN-1:0] instr_o,
  output logic            instr_valid_o,
  input  logic            ctrl_wen_i,
  output logic            reg_wen_o,
  input  logic            halt_req_i,
  output logic            halted_o,
  output logic            fault_o,
  output logic [63:0]     instret_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_e;

  // Count value seen on the last tolerated wait cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [ILEN-1:0]   instr_q, instr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [63:0]       instret_q, instret_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      instr_q   <= '0;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    tmo_d     = tmo_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        if (halt_req_i) begin
          state_d = S_HALTED;
        end else begin
          addr_d  = pc_in_i;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Pending fetch is never abandoned; halt_req is deliberately ignored here.
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          tmo_d   = '0;
          state_d = S_EXEC;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_FAULT;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_EXEC: begin
        instret_d = instret_q + 64'd1;
        state_d   = halt_req_i ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (!halt_req_i) state_d = S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and gating outputs depend on state only, never on imem_ready.
  assign imem_req_o    = (state_q == S_FETCH);
  assign instr_valid_o = (state_q == S_EXEC);
  assign pc_step_o     = (state_q == S_EXEC);
  assign reg_wen_o     = (state_q == S_EXEC) & ctrl_wen_i;
  assign halted_o      = (state_q == S_HALTED);
  assign fault_o       = (state_q == S_FAULT);
  assign imem_addr_o   = addr_q;
  assign instr_o       = instr_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Scoreboard bench: stimulus pushes expected EXEC transactions, a negedge
// monitor pops and compares them; directed checks cover halt, timeout and reset.
module tb_fetch_exec_sequencer;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc;
  logic            pc_step;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [ILEN-1:0] imem_rdata;
  logic [ILEN-1:0] instr;
  logic            instr_valid;
  logic            ctrl_wen;
  logic            reg_wen;
  logic            halt_req;
  logic            halted;
  logic            fault;
  logic [63:0]     instret;

  typedef struct {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] instr;
    logic            wen;
    logic [63:0]     ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  fetch_exec_sequencer #(.XLEN(XLEN), .ILEN(ILEN), .TMO_W(8), .TMO_MAX(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_in_i      (pc),
    .pc_step_o    (pc_step),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr),
    .instr_valid_o(instr_valid),
    .ctrl_wen_i   (ctrl_wen),
    .reg_wen_o    (reg_wen),
    .halt_req_i   (halt_req),
    .halted_o     (halted),
    .fault_o      (fault),
    .instret_o    (instret)
  );

  // Simple pc register and instruction memory: word at addr a is a ^ 0x00500093.
  always @(posedge clk) begin
    if (rst)          pc <= '0;
    else if (pc_step) pc <= pc + 64'd4;
  end
  assign imem_rdata = imem_addr[31:0] ^ 32'h0050_0093;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},     {63'd0, imem_req},    64'd0);
    chk({tag, "_addr"},    imem_addr,            64'd0);
    chk({tag, "_instr"},   {32'd0, instr},       64'd0);
    chk({tag, "_ivalid"},  {63'd0, instr_valid}, 64'd0);
    chk({tag, "_pcstep"},  {63'd0, pc_step},     64'd0);
    chk({tag, "_regwen"},  {63'd0, reg_wen},     64'd0);
    chk({tag, "_halted"},  {63'd0, halted},      64'd0);
    chk({tag, "_fault"},   {63'd0, fault},       64'd0);
    chk({tag, "_instret"}, instret,              64'd0);
  endtask

  // Monitor: every EXEC cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("wen_outside_exec", {63'd0, reg_wen & ~instr_valid}, 64'd0);
      chk("step_outside_exec", {63'd0, pc_step & ~instr_valid}, 64'd0);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_exec", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("exec_instr",   {32'd0, instr},   {32'd0, e.instr});
          chk("exec_addr",    imem_addr,        e.addr);
          chk("exec_regwen",  {63'd0, reg_wen}, {63'd0, e.wen});
          chk("exec_pcstep",  {63'd0, pc_step}, 64'd1);
          chk("exec_instret", instret,          e.ret);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b1; halt_req = 1'b0; ctrl_wen = 1'b1;
    exp_q.push_back('{addr: 64'h0, instr: 32'h0050_0093, wen: 1'b1, ret: 64'd0});
    exp_q.push_back('{addr: 64'h4, instr: 32'h0050_0097, wen: 1'b0, ret: 64'd1});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; started = 1'b1;
    @(negedge clk); chk_reset_vals("reset");

    // Test 1: zero-wait fetch, EXEC on third cycle, next fetch at 0x4.
    nxt(); @(negedge clk);
    chk("t1_req", {63'd0, imem_req}, 64'd1);
    chk("t1_addr", imem_addr, 64'h0);
    nxt();                                  // EXEC insn0
    nxt(); ctrl_wen = 1'b0; @(negedge clk);
    chk("t1_instret", instret, 64'd1);
    chk("t1_idle_req", {63'd0, imem_req}, 64'd0);

    // Test 4: halt raised during FETCH lets the instruction finish.
    nxt(); halt_req = 1'b1; @(negedge clk);
    chk("t4_req", {63'd0, imem_req}, 64'd1);
    chk("t4_addr", imem_addr, 64'h4);
    nxt();                                  // EXEC insn1
    nxt(); imem_ready = 1'b0; @(negedge clk);
    chk("t4_halted", {63'd0, halted}, 64'd1);
    chk("t4_req_halted", {63'd0, imem_req}, 64'd0);
    chk("t4_instret", instret, 64'd2);
    nxt();
    nxt(); halt_req = 1'b0; ctrl_wen = 1'b1;
    exp_q.push_back('{addr: 64'h8, instr: 32'h0050_009B, wen: 1'b1, ret: 64'd2});
    @(negedge clk); chk("t4_still_halted", {63'd0, halted}, 64'd1);
    nxt(); @(negedge clk);
    chk("t4_resume_idle", {63'd0, halted | imem_req}, 64'd0);

    // Test 2: three wait cycles, then ready; instr held until the ready edge.
    nxt();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_req_wait", {63'd0, imem_req}, 64'd1);
      chk("t2_addr_wait", imem_addr, 64'h8);
      chk("t2_instr_held", {32'd0, instr}, 64'h0050_0097);
      nxt();
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_ready", {63'd0, imem_req}, 64'd1);
    nxt(); halt_req = 1'b1;                 // EXEC insn2
    nxt(); halt_req = 1'b0; imem_ready = 1'b0; @(negedge clk);
    chk("t2_halted", {63'd0, halted}, 64'd1);
    chk("t2_instret", instret, 64'd3);

    // Test 3: ready never returns; fault after 4 wait cycles.
    nxt();                                  // IDLE
    nxt();                                  // first FETCH cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_req_wait", {63'd0, imem_req}, 64'd1);
      chk("t3_addr_wait", imem_addr, 64'hC);
      chk("t3_nofault_yet", {63'd0, fault}, 64'd0);
      nxt();
    end
    for (int k = 0; k < 50; k++) begin
      imem_ready = k[0]; ctrl_wen = 1'b1;
      @(negedge clk);
      chk("t3_fault", {63'd0, fault}, 64'd1);
      chk("t3_req", {63'd0, imem_req}, 64'd0);
      chk("t3_regwen", {63'd0, reg_wen}, 64'd0);
      chk("t3_instret", instret, 64'd3);
      nxt();
    end
    rst = 1'b1; imem_ready = 1'b0;
    nxt(); rst = 1'b0;
    @(negedge clk); chk_reset_vals("t3_after_rst");

    // Test 5: reset in FETCH with ready in the same cycle.
    nxt(); @(negedge clk);
    chk("t5_req", {63'd0, imem_req}, 64'd1);
    nxt(); rst = 1'b1; imem_ready = 1'b1; ctrl_wen = 1'b1;
    @(negedge clk);
    chk("t5_regwen_fetch", {63'd0, reg_wen}, 64'd0);
    nxt(); rst = 1'b0; halt_req = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    chk("t5_req_dropped", {63'd0, imem_req}, 64'd0);
    chk("t5_instret", instret, 64'd0);
    chk("t5_instr", {32'd0, instr}, 64'd0);
    nxt(); @(negedge clk);
    chk("t5_halted", {63'd0, halted}, 64'd1);
    repeat (3) nxt();
    @(negedge clk);
    chk("t5_instret_final", instret, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
